// File: rtl/cube_sequencer_pkg.sv
// cube_sequencer_pkg: state codes, error codes and helpers shared by the cube sequencer.
// Rev 1.0
`default_nettype none

package cube_sequencer_pkg;

  typedef enum logic [3:0] {
    ST_INICIAL            = 4'd0,
    ST_PREPARA            = 4'd1,
    ST_RECEBE_IMAGEM      = 4'd2,
    ST_IDENTIFICA_CORES   = 4'd3,
    ST_TRANSMITE_CORES    = 4'd4,
    ST_MUDA_FACE          = 4'd5,
    ST_ATUALIZA_PASSO     = 4'd6,
    ST_ATUALIZA_FACE      = 4'd7,
    ST_RECEBE_MOVIMENTOS  = 4'd8,
    ST_PREPARA_MOVIMENTOS = 4'd9,
    ST_MOVIMENTA          = 4'd10,
    ST_ATUALIZA_MOVIMENTO = 4'd11,
    ST_FIM                = 4'd12,
    ST_POSICAO_INICIAL    = 4'd13,
    ST_ERRO               = 4'd14,
    ST_ILEGAL             = 4'd15
  } estado_t;

  typedef enum logic [1:0] {
    ERR_NENHUM    = 2'd0,
    ERR_IMAGEM    = 2'd1,
    ERR_SERIAL    = 2'd2,
    ERR_MOVIMENTO = 2'd3
  } erro_cod_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << r) < value) r = r + 1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cube_watchdog.sv
// cube_watchdog: per-state wait counter; expired_o flags the last allowed cycle of a wait.
// Rev 1.0
`default_nettype none

module cube_watchdog #(
  parameter int TIMEOUT_CYCLES = 50_000_000,
  parameter int TIMEOUT_W      = 26
) (
  input  logic clock,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  logic [TIMEOUT_W-1:0] count_q;
  logic [TIMEOUT_W-1:0] count_d;

  assign expired_o = (count_q == TIMEOUT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && !expired_o) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/cube_sequencer_uc.sv
// cube_sequencer_uc: control FSM for scanning N_FACES cube faces and replaying the solution.
// Rev 1.0
`default_nettype none

module cube_sequencer_uc
  import cube_sequencer_pkg::*;
#(
  parameter int N_FACES        = 6,
  parameter int MOVES_PER_FACE = 2,
  parameter int TIMEOUT_CYCLES = 50_000_000,
  parameter int TIMEOUT_W      = 26
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       abortar,
  input  logic       imagem_recebida,
  input  logic       cores_identificadas,
  input  logic       cores_transmitidas,
  input  logic       fim_movimento,
  input  logic       movimentos_recebidos,
  input  logic       fim_rom,
  output logic       zera_movimento,
  output logic       captura_imagem,
  output logic       identificar_cores,
  output logic       enviar_cores,
  output logic       aciona_movimento,
  output logic       conta_movimento,
  output logic       obter_movimentos,
  output logic       sel_ram_pixel,
  output logic       sel_cor,
  output logic       sel_serial1,
  output logic       sel_serial2,
  output logic       sel_movimento,
  output logic       pronto,
  output logic       erro,
  output logic [3:0] face_idx,
  output logic [3:0] db_estado,
  output logic [1:0] db_erro_cod
);

  localparam int PASSO_W = (MOVES_PER_FACE > 1) ? clog2(MOVES_PER_FACE) : 1;

  estado_t              state_q, state_d;
  erro_cod_t            erro_cod_q, erro_cod_d;
  erro_cod_t            wait_cod;
  logic [3:0]           face_q, face_d;
  logic [PASSO_W-1:0]   passo_q, passo_d;
  logic                 done;
  logic                 wd_clear;
  logic                 wd_expired;

  cube_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TIMEOUT_W      (TIMEOUT_W)
  ) u_watchdog (
    .clock     (clock),
    .reset     (reset),
    .clear_i   (wd_clear),
    .enable_i  (wait_cod != ERR_NENHUM),
    .expired_o (wd_expired)
  );

  always_comb begin
    state_d    = state_q;
    face_d     = face_q;
    passo_d    = passo_q;
    erro_cod_d = erro_cod_q;
    done       = 1'b0;
    wait_cod   = ERR_NENHUM;
    case (state_q)
      ST_INICIAL:            if (iniciar) state_d = ST_PREPARA;
      ST_PREPARA: begin
        face_d  = '0;
        passo_d = '0;
        state_d = ST_RECEBE_IMAGEM;
      end
      ST_RECEBE_IMAGEM: begin
        done     = imagem_recebida;
        wait_cod = ERR_IMAGEM;
        if (done) state_d = ST_IDENTIFICA_CORES;
      end
      ST_IDENTIFICA_CORES: begin
        done     = cores_identificadas;
        wait_cod = ERR_IMAGEM;
        if (done) state_d = ST_TRANSMITE_CORES;
      end
      ST_TRANSMITE_CORES: begin
        done     = cores_transmitidas;
        wait_cod = ERR_SERIAL;
        if (done) state_d = (face_q == 4'(N_FACES - 1)) ? ST_POSICAO_INICIAL : ST_MUDA_FACE;
      end
      ST_MUDA_FACE: begin
        done     = fim_movimento;
        wait_cod = ERR_MOVIMENTO;
        if (done) state_d = ST_ATUALIZA_PASSO;
      end
      ST_ATUALIZA_PASSO: begin
        if (passo_q == PASSO_W'(MOVES_PER_FACE - 1)) begin
          passo_d = '0;
          state_d = ST_ATUALIZA_FACE;
        end else begin
          passo_d = passo_q + 1'b1;
          state_d = ST_MUDA_FACE;
        end
      end
      ST_ATUALIZA_FACE: begin
        face_d  = face_q + 4'd1;
        state_d = ST_RECEBE_IMAGEM;
      end
      ST_RECEBE_MOVIMENTOS: begin
        done     = movimentos_recebidos;
        wait_cod = ERR_SERIAL;
        if (done) state_d = ST_PREPARA_MOVIMENTOS;
      end
      ST_PREPARA_MOVIMENTOS: state_d = ST_MOVIMENTA;
      ST_MOVIMENTA: begin
        done     = fim_movimento;
        wait_cod = ERR_MOVIMENTO;
        if (done) state_d = ST_ATUALIZA_MOVIMENTO;
      end
      ST_ATUALIZA_MOVIMENTO: state_d = fim_rom ? ST_FIM : ST_MOVIMENTA;
      ST_FIM:                if (iniciar) state_d = ST_PREPARA;
      ST_POSICAO_INICIAL: begin
        done     = fim_movimento;
        wait_cod = ERR_MOVIMENTO;
        if (done) state_d = ST_RECEBE_MOVIMENTOS;
      end
      ST_ERRO: begin
        if (iniciar) begin
          state_d    = ST_INICIAL;
          erro_cod_d = ERR_NENHUM;
        end
      end
      default:               state_d = ST_INICIAL;
    endcase

    // A done flag arriving on the expiry cycle still wins over the timeout.
    if ((wait_cod != ERR_NENHUM) && !done && wd_expired) begin
      state_d    = ST_ERRO;
      erro_cod_d = wait_cod;
    end

    if (abortar) begin
      state_d    = ST_INICIAL;
      face_d     = '0;
      passo_d    = '0;
      erro_cod_d = ERR_NENHUM;
    end

    wd_clear = abortar || (state_d != state_q);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_INICIAL;
      erro_cod_q <= ERR_NENHUM;
      face_q     <= '0;
      passo_q    <= '0;
    end else begin
      state_q    <= state_d;
      erro_cod_q <= erro_cod_d;
      face_q     <= face_d;
      passo_q    <= passo_d;
    end
  end

  assign zera_movimento    = (state_q == ST_PREPARA) || (state_q == ST_PREPARA_MOVIMENTOS);
  assign captura_imagem    = (state_q == ST_RECEBE_IMAGEM);
  assign sel_ram_pixel     = (state_q == ST_RECEBE_IMAGEM);
  assign identificar_cores = (state_q == ST_IDENTIFICA_CORES);
  assign sel_cor           = (state_q == ST_IDENTIFICA_CORES);
  assign enviar_cores      = (state_q == ST_TRANSMITE_CORES);
  assign aciona_movimento  = (state_q == ST_MUDA_FACE) || (state_q == ST_POSICAO_INICIAL) ||
                             (state_q == ST_MOVIMENTA);
  assign conta_movimento   = (state_q == ST_ATUALIZA_PASSO) || (state_q == ST_ATUALIZA_MOVIMENTO);
  assign obter_movimentos  = (state_q == ST_RECEBE_MOVIMENTOS);
  assign sel_serial2       = (state_q == ST_RECEBE_MOVIMENTOS);
  assign sel_movimento     = (state_q == ST_RECEBE_MOVIMENTOS);
  assign sel_serial1       = (state_q == ST_TRANSMITE_CORES) || (state_q == ST_RECEBE_MOVIMENTOS);
  assign pronto            = (state_q == ST_FIM);
  assign erro              = (state_q == ST_ERRO);
  assign face_idx          = face_q;
  assign db_estado         = state_q;
  assign db_erro_cod       = erro_cod_q;

endmodule

`default_nettype wire

// File: tb/tb_cube_sequencer_uc.sv
// tb_cube_sequencer_uc: directed scenarios plus randomized flags against a behavioural model.
// Rev 1.0
`default_nettype none

module tb_cube_sequencer_uc;

  localparam int NF  = 6;
  localparam int MPF = 2;
  localparam int TO  = 16;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic iniciar = 1'b0, abortar = 1'b0;
  logic imagem_recebida = 1'b0, cores_identificadas = 1'b0, cores_transmitidas = 1'b0;
  logic fim_movimento = 1'b0, movimentos_recebidos = 1'b0, fim_rom = 1'b0;
  logic zera_movimento, captura_imagem, identificar_cores, enviar_cores, aciona_movimento;
  logic conta_movimento, obter_movimentos, sel_ram_pixel, sel_cor, sel_serial1, sel_serial2;
  logic sel_movimento, pronto, erro;
  logic [3:0] face_idx, db_estado;
  logic [1:0] db_erro_cod;

  cube_sequencer_uc #(
    .N_FACES(NF), .MOVES_PER_FACE(MPF), .TIMEOUT_CYCLES(TO), .TIMEOUT_W(5)
  ) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .abortar(abortar),
    .imagem_recebida(imagem_recebida), .cores_identificadas(cores_identificadas),
    .cores_transmitidas(cores_transmitidas), .fim_movimento(fim_movimento),
    .movimentos_recebidos(movimentos_recebidos), .fim_rom(fim_rom),
    .zera_movimento(zera_movimento), .captura_imagem(captura_imagem),
    .identificar_cores(identificar_cores), .enviar_cores(enviar_cores),
    .aciona_movimento(aciona_movimento), .conta_movimento(conta_movimento),
    .obter_movimentos(obter_movimentos), .sel_ram_pixel(sel_ram_pixel), .sel_cor(sel_cor),
    .sel_serial1(sel_serial1), .sel_serial2(sel_serial2), .sel_movimento(sel_movimento),
    .pronto(pronto), .erro(erro), .face_idx(face_idx), .db_estado(db_estado),
    .db_erro_cod(db_erro_cod)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_bad = 0;

  // Behavioural model: state number, face/step counters, cycles spent in current state.
  int m_state = 0, m_face = 0, m_passo = 0, m_age = 0, m_err = 0;
  int wcode [16] = '{0, 0, 1, 1, 2, 3, 0, 0, 2, 0, 3, 0, 0, 3, 0, 0};

  wire [13:0] dut_ctl = {zera_movimento, captura_imagem, identificar_cores, enviar_cores,
                         aciona_movimento, conta_movimento, obter_movimentos, sel_ram_pixel,
                         sel_cor, sel_serial1, sel_serial2, sel_movimento, pronto, erro};

  function automatic logic [13:0] exp_ctl(input int s);
    return {s == 1 || s == 9, s == 2, s == 3, s == 4, s == 5 || s == 10 || s == 13,
            s == 6 || s == 11, s == 8, s == 2, s == 3, s == 4 || s == 8, s == 8, s == 8,
            s == 12, s == 14};
  endfunction

  function automatic bit flag_of(input int s);
    case (s)
      2:           return imagem_recebida;
      3:           return cores_identificadas;
      4:           return cores_transmitidas;
      5, 10, 13:   return fim_movimento;
      8:           return movimentos_recebidos;
      default:     return 1'b0;
    endcase
  endfunction

  task automatic model_step();
    int nxt;
    bit done;
    nxt  = m_state;
    done = flag_of(m_state);
    if (abortar) begin
      nxt = 0; m_face = 0; m_passo = 0; m_err = 0;
    end else if (wcode[m_state] != 0 && !done && m_age == TO - 1) begin
      nxt = 14; m_err = wcode[m_state];
    end else begin
      case (m_state)
        0:  if (iniciar) nxt = 1;
        1:  begin m_face = 0; m_passo = 0; nxt = 2; end
        2:  if (done) nxt = 3;
        3:  if (done) nxt = 4;
        4:  if (done) nxt = (m_face == NF - 1) ? 13 : 5;
        5:  if (done) nxt = 6;
        6:  if (m_passo == MPF - 1) begin m_passo = 0; nxt = 7; end
            else begin m_passo = m_passo + 1; nxt = 5; end
        7:  begin m_face = m_face + 1; nxt = 2; end
        8:  if (done) nxt = 9;
        9:  nxt = 10;
        10: if (done) nxt = 11;
        11: nxt = fim_rom ? 12 : 10;
        12: if (iniciar) nxt = 1;
        13: if (done) nxt = 8;
        14: if (iniciar) begin nxt = 0; m_err = 0; end
        default: nxt = 0;
      endcase
    end
    m_age   = (nxt != m_state) ? 0 : m_age + 1;
    m_state = nxt;
  endtask

  initial begin
    forever begin
      @(posedge clock or posedge reset);
      if (reset) begin
        m_state = 0; m_face = 0; m_passo = 0; m_age = 0; m_err = 0;
      end else begin
        model_step();
      end
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      n_vec++;
      if ({dut_ctl, face_idx, db_estado, db_erro_cod} !==
          {exp_ctl(m_state), 4'(m_face), 4'(m_state), 2'(m_err)}) begin
        n_bad++;
        $display("FAIL model_cmp t=%0t: got ctl=%b face=%0d st=%0d ec=%0d, expected ctl=%b face=%0d st=%0d ec=%0d",
                 $time, dut_ctl, face_idx, db_estado, db_erro_cod,
                 exp_ctl(m_state), m_face, m_state, m_err);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic all_flags(input logic v);
    imagem_recebida = v; cores_identificadas = v; cores_transmitidas = v;
    fim_movimento = v; movimentos_recebidos = v;
  endtask

  task automatic wait_state(input int s, input int face, input int budget);
    int n;
    n = 0;
    while (!(db_estado == 4'(s) && (face < 0 || face_idx == 4'(face))) && n < budget) begin
      tick();
      n++;
    end
    chk("reach_state", int'(db_estado), s);
  endtask

  // Full scan + replay with responsive flags and a three-move ROM.
  task automatic full_run();
    int prev, c11, maxf, n, nzera;
    int ent [16];
    all_flags(1'b1);
    fim_rom = 1'b0;
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    chk("start_prepara", int'(db_estado), 1);
    chk("start_zera", int'(zera_movimento), 1);
    foreach (ent[i]) ent[i] = 0;
    prev = 1; c11 = 0; maxf = 0; n = 0; nzera = 0;
    while (pronto !== 1'b1 && n < 600) begin
      if (int'(db_estado) != prev) ent[db_estado]++;
      prev = int'(db_estado);
      if (db_estado == 4'd11) c11++;
      if (zera_movimento) nzera++;
      if (int'(face_idx) > maxf) maxf = int'(face_idx);
      fim_rom = (db_estado == 4'd11 && c11 == 3);
      tick();
      n++;
    end
    fim_rom = 1'b0;
    chk("entries_st2", ent[2], 6);
    chk("entries_st3", ent[3], 6);
    chk("entries_st4", ent[4], 6);
    chk("entries_muda_face", ent[5], 10);
    chk("entries_st13", ent[13], 1);
    chk("conta_pulses_st11", c11, 3);
    chk("zera_cycles", nzera, 2);
    chk("max_face", maxf, 5);
    chk("end_pronto", int'(pronto), 1);
    chk("end_face", int'(face_idx), 5);
    chk("end_state", int'(db_estado), 12);
  endtask

  initial begin
    #1 reset = 1'b1;
    tick();
    chk("rst_state", int'(db_estado), 0);
    chk("rst_ctl", int'(dut_ctl), 0);
    chk("rst_face", int'(face_idx), 0);
    chk("rst_errcod", int'(db_erro_cod), 0);
    tick();
    reset = 1'b0;
    tick();

    full_run();
    full_run();

    // Abort in MOVIMENTA, then restart.
    all_flags(1'b1);
    iniciar = 1'b1; tick(); iniciar = 1'b0;
    wait_state(10, -1, 600);
    abortar = 1'b1; tick(); abortar = 1'b0;
    chk("abort_state", int'(db_estado), 0);
    chk("abort_ctl", int'(dut_ctl), 0);
    chk("abort_face", int'(face_idx), 0);
    chk("abort_errcod", int'(db_erro_cod), 0);
    iniciar = 1'b1; tick(); iniciar = 1'b0;
    chk("restart_prepara", int'(db_estado), 1);
    chk("restart_face", int'(face_idx), 0);

    // Image never arrives: error exactly TO cycles after entering state 2.
    imagem_recebida = 1'b0;
    tick();
    chk("to_enter_st2", int'(db_estado), 2);
    for (int k = 1; k <= TO; k++) begin
      tick();
      if (k < TO) chk("to_no_erro_yet", int'(erro), 0);
    end
    chk("to_erro", int'(erro), 1);
    chk("to_state", int'(db_estado), 14);
    chk("to_errcod", int'(db_erro_cod), 1);
    iniciar = 1'b1; tick(); iniciar = 1'b0;
    chk("clr_state", int'(db_estado), 0);
    chk("clr_errcod", int'(db_erro_cod), 0);

    // cores_transmitidas on the expiry edge: transition wins.
    imagem_recebida = 1'b1;
    cores_transmitidas = 1'b0;
    iniciar = 1'b1; tick(); iniciar = 1'b0;
    wait_state(4, -1, 50);
    for (int k = 1; k < TO; k++) tick();
    chk("race_still_st4", int'(db_estado), 4);
    cores_transmitidas = 1'b1;
    tick();
    chk("race_state", int'(db_estado), 5);
    chk("race_erro", int'(erro), 0);
    chk("race_errcod", int'(db_erro_cod), 0);

    // Async reset while in ATUALIZA_FACE of the second face.
    all_flags(1'b1);
    wait_state(7, 1, 100);
    #2 reset = 1'b1;
    #1;
    chk("arst_state", int'(db_estado), 0);
    chk("arst_face", int'(face_idx), 0);
    chk("arst_ctl", int'(dut_ctl), 0);
    tick();
    reset = 1'b0;
    tick();

    // Randomized flags with varying responsiveness.
    for (int blk = 0; blk < 15; blk++) begin
      int p;
      p = (blk % 3 == 0) ? 95 : ((blk % 3 == 1) ? 50 : 8);
      for (int c = 0; c < 200; c++) begin
        imagem_recebida      = ($urandom % 100) < p;
        cores_identificadas  = ($urandom % 100) < p;
        cores_transmitidas   = ($urandom % 100) < p;
        fim_movimento        = ($urandom % 100) < p;
        movimentos_recebidos = ($urandom % 100) < p;
        fim_rom              = ($urandom % 3) == 0;
        iniciar              = ($urandom % 15) == 0;
        abortar              = ($urandom % 200) == 0;
        tick();
      end
    end
    iniciar = 1'b0;
    abortar = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
